// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word, RAM status and arbiter state encodings.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [1:0] {ARB_IDLE, ARB_IGNT, ARB_DGNT} arbstate_t;

  // Consecutive data grants allowed while an instruction fetch waits.
  parameter int unsigned DSTREAK_MAX_DEFAULT = 4;

endpackage

// File: rtl/ram_arbiter_if.sv
// Port bundle between the cache request channels, the arbiter and the RAM.
interface ram_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport arb (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport tb (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/ram_arbiter.sv
// Grants the single-ported RAM to the data or instruction channel, holding each grant
// until ACCESS; data wins ties unless the instruction channel has waited DSTREAK_MAX grants.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned DSTREAK_MAX = DSTREAK_MAX_DEFAULT
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  localparam int unsigned SW = $clog2(DSTREAK_MAX + 1);
  localparam logic [SW-1:0] StreakMax = SW'(DSTREAK_MAX);

  arbstate_t     state_q, state_d;
  logic [SW-1:0] dstreak_q, dstreak_d;
  logic          dreq;

  assign dreq  = dREN | dWEN;
  assign iload = ramload;
  assign dload = ramload;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= ARB_IDLE;
      dstreak_q <= '0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dstreak_d = dstreak_q;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    iwait     = 1'b1;
    dwait     = 1'b1;
    unique case (state_q)
      ARB_IDLE: begin
        if (!iREN) dstreak_d = '0;
        if (dreq && (dstreak_q < StreakMax || !iREN)) begin
          state_d = ARB_DGNT;
        end else if (iREN) begin
          state_d = ARB_IGNT;
        end
      end
      ARB_DGNT: begin
        // A simultaneous read and write is illegal; the write takes the bus.
        ramREN   = dREN & ~dWEN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (ramstate == ACCESS) begin
          dwait   = 1'b0;
          state_d = ARB_IDLE;
          if (iREN && dstreak_q < StreakMax) dstreak_d = dstreak_q + 1'b1;
        end else if (ramstate == ERROR || !dreq) begin
          state_d = ARB_IDLE;
        end
      end
      ARB_IGNT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (ramstate == ACCESS) begin
          iwait     = 1'b0;
          state_d   = ARB_IDLE;
          dstreak_d = '0;
        end else if (ramstate == ERROR || !iREN) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Arbitrates the single-ported RAM between the instruction-cache and data-cache request channels. Sits between the caches and the RAM model and owns the RAM's REN/WEN/addr/store lines. It sequences each transfer through a grant state machine that holds the grant until the RAM reports `ACCESS`. Data reads take priority, and a starvation counter bounds instruction-fetch latency.

## Interface
Parameters:
- `DSTREAK_MAX`, default 4: maximum consecutive data grants allowed while an instruction request is pending.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `iREN`  in  1  instruction read request.
- `iaddr`  in  `word_t`  instruction address.
- `iwait`  out  1  high while the instruction request is not complete.
- `iload`  out  `word_t`  instruction read data.
- `dREN`  in  1  data read request.
- `dWEN`  in  1  data write request.
- `daddr`  in  `word_t`  data address.
- `dstore`  in  `word_t`  data write value.
- `dwait`  out  1  high while the data request is not complete.
- `dload`  out  `word_t`  data read data.
- `ramREN`  out  1  RAM read enable.
- `ramWEN`  out  1  RAM write enable.
- `ramaddr`  out  `word_t`  RAM address.
- `ramstore`  out  `word_t`  RAM write data.
- `ramload`  in  `word_t`  RAM read data.
- `ramstate`  in  `ramstate_t`  RAM status: `FREE`, `BUSY`, `ACCESS` or `ERROR`.

## Operation
- States: `ARB_IDLE`, `ARB_IGNT`, `ARB_DGNT`.
- **In `ARB_IDLE`:**
  - `ramREN` and `ramWEN` are 0; `ramaddr` and `ramstore` are 0.
  - If a data request (`dREN|dWEN`) is pending and `dstreak < DSTREAK_MAX` or `iREN` is 0, go to `ARB_DGNT`.
  - Otherwise, if `iREN` is 1, go to `ARB_IGNT`.
  - Otherwise stay.
- **In `ARB_DGNT`:**
  - Drive `ramREN=dREN`, `ramWEN=dWEN`, `ramaddr=daddr`, `ramstore=dstore`.
  - `dREN` and `dWEN` both high is illegal; the write wins (`ramREN` is forced to 0).
- **In `ARB_IGNT`:**
  - Drive `ramREN=1`, `ramWEN=0`, `ramaddr=iaddr`.
- **In a grant state:**
  - `ramstate==ACCESS` completes the transfer: the granted `*wait` is 0 in that cycle, and the next state is `ARB_IDLE`.
  - `FREE` or `BUSY` means stay.
  - `ERROR` means return to `ARB_IDLE` without completing; the granted `*wait` stays 1, so the request is re-arbitrated (retry).
- **Request withdrawn mid-grant:** if the granted request drops before `ACCESS`, return to `ARB_IDLE` the next cycle. Nothing completes.
- `iwait = !(state==ARB_IGNT && ramstate==ACCESS)`; `dwait` is analogous for `ARB_DGNT`. Both waits are 1 whenever their channel is not being completed, including when idle.
- `iload` and `dload` are `ramload` passed through combinationally, valid only in the completing cycle.
- **`dstreak` counter** (width `$clog2(DSTREAK_MAX+1)`):
  - Increments on each completed data grant while `iREN` is 1.
  - Saturates at `DSTREAK_MAX`.
  - Clears on a completed instruction grant, or whenever `iREN` is 0 in `ARB_IDLE`.

## Timing
- **Reset:** asynchronous on `nRST` low.
  - State is `ARB_IDLE` and `dstreak` is 0.
  - All RAM outputs are 0.
  - `iwait` and `dwait` are 1; `iload` and `dload` follow `ramload`.
  - Reset mid-grant aborts the transfer immediately; no completion is reported.
- **Latency:** a request is sampled in `ARB_IDLE` at edge N, and the RAM lines are driven from cycle N+1. With a RAM latency of L cycles to `ACCESS`, `*wait` falls in cycle N+L.
- **Bubble:** there is one mandatory `ARB_IDLE` cycle between consecutive grants, so two back-to-back transfers on a zero-wait RAM take 4 cycles.
- **Simultaneous `iREN` and `dREN`/`dWEN` in `ARB_IDLE`:** the data channel wins unless `dstreak==DSTREAK_MAX`.
- **Request changes:** a requester must hold its request and address stable until its `*wait` is 0. An address change mid-grant is passed to the RAM as-is; the arbiter does not check it.
- The outputs are a combinational function of state and inputs. The only registers are the state and `dstreak`.

## Structure
- In `cpu_types_pkg`:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_IGNT, ARB_DGNT} arbstate_t`.
  - `DSTREAK_MAX` default, as a package parameter.
- Reuses `word_t` and `ramstate_t` from `cpu_types_pkg`.
- Port bundle: a `ram_arbiter_if` interface with `arb` and `tb` modports.
- No sub-module is required. If a second instance of the priority logic is ever needed, split it out as `arb_priority`.

## Test plan
- **Data read:** `dREN=1`, `daddr=0x40`, RAM returns `ACCESS` on its 2nd cycle with `ramload=0xDEADBEEF` → `ramaddr=0x40`, `dwait` falls in cycle 3 after the request with `dload=0xDEADBEEF`, `iwait` stays 1.
- **Contention:** `iREN` and `dREN` both asserted in the same idle cycle, zero-wait RAM → data granted first, instruction granted after one `ARB_IDLE` bubble.
- **Starvation:** `iREN` held with a continuous data stream, `DSTREAK_MAX=4` → exactly 4 data completions, then an instruction grant, then `dstreak` is 0.
- **RAM error:** `ramstate=ERROR` during `ARB_DGNT` → return to `ARB_IDLE`, `dwait` stays 1, the request is re-granted and completes on the following `ACCESS`.
- **Write:** `dWEN=1`, `daddr=0x80`, `dstore=0x1234` → `ramWEN=1`, `ramREN=0`, `ramstore=0x1234`. Same test with `dREN=dWEN=1` → `ramREN=0`.
- **Reset:** `nRST` driven low mid-`ARB_IGNT`, asynchronously between edges → `ramREN` drops immediately, `iwait=1`, state is `ARB_IDLE` after release.
